strike_detector: RTL and testbench
==================================

STRIKE_DETECTOR -- requirements
Module: strike_detector

Interface
REQ-001 Parameter COST_W, default 16: candidate cost width in bits.
REQ-002 Parameter STRIKE_LIMIT, default 4'd8: strike_count value at or above which the search is done.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active high.
REQ-004 start  input  1  single-cycle request to begin a new search; clears the best-cost record.
REQ-005 cost_in  input  COST_W  candidate placement cost, unsigned.
REQ-006 cost_valid  input  1  cost_in is valid this cycle.
REQ-007 cost_ready  output  1  the block accepts cost_in this cycle.
REQ-008 strike_count  input  4  current count fed back from the downstream strike counter.
REQ-009 strike_flag  output  1  one-cycle pulse when an accepted candidate does not improve the best cost; feeds the downstream counter.
REQ-010 improve_flag  output  1  one-cycle pulse when an accepted candidate becomes the new best.
REQ-011 best_cost  output  COST_W  lowest cost accepted since the last start.
REQ-012 best_valid  output  1  best_cost holds at least one accepted candidate.
REQ-013 cand_count  output  8  number of candidates accepted since the last start; saturates at 255.
REQ-014 done  output  1  the search has terminated on the strike limit.

Function
REQ-015 The state machine SHALL have three states: IDLE, RUN and DONE. It SHALL be encoded in 2 bits, and unused encodings SHALL return to IDLE.
REQ-016 cost_ready SHALL equal (state==RUN) & ~start and SHALL be combinational. It is the only combinational output.
REQ-017 A candidate is accepted in any cycle where cost_valid & cost_ready.
REQ-018 Transitions:
- IDLE->RUN on start.
- RUN->RUN on start (restart).
- RUN->DONE when strike_count >= STRIKE_LIMIT, sampled in RUN with start low.
- DONE->RUN on start.
- No other transitions.
REQ-019 On every start, in any state: best_valid<=0, best_cost<=0, cand_count<=0, done<=0.
REQ-020 On an accepted candidate when best_valid==0, or when cost_in < best_cost (unsigned compare):
- best_cost<=cost_in;
- best_valid<=1;
- improve_flag<=1 in the next cycle.
REQ-021 On an accepted candidate when best_valid==1 and cost_in >= best_cost:
- strike_flag<=1 in the next cycle;
- best_cost is unchanged.
- An equal cost counts as a strike.
REQ-022 strike_flag and improve_flag are registered, have one-cycle latency from acceptance, are mutually exclusive, and are 0 in every cycle with no acceptance.
REQ-023 cand_count SHALL increment by 1 per accepted candidate and hold at 8'hFF.
REQ-024 done SHALL be registered high in the cycle after the RUN->DONE transition and SHALL remain high through DONE until start.
REQ-025 A candidate accepted in the same cycle that the strike limit is detected SHALL still be evaluated, and its flag SHALL still pulse.
REQ-026 When start and cost_valid are both high, start wins: the candidate is not accepted, and the source must hold it.
REQ-027 In IDLE and DONE: cost_ready=0, no flags pulse, and best_cost, best_valid and cand_count hold.
REQ-028 The block SHALL never reset the downstream counter. Clearing strike_count is the system's responsibility via rst.

Reset
REQ-029 When rst is high at a rising edge:
- state<=IDLE;
- best_cost<=0, best_valid<=0, cand_count<=0;
- strike_flag<=0, improve_flag<=0, done<=0.
REQ-030 rst SHALL take priority over start and cost_valid. Reset mid-RUN SHALL discard a candidate presented in the same cycle.

Verification
REQ-031 Costs 100, 80, 90 are accepted in consecutive cycles after start -> the bench SHALL observe:
- improve_flag on the 1st and 2nd following cycles;
- strike_flag on the 3rd;
- best_cost=80, cand_count=3.
REQ-032 Cost 50 twice with strike_count=0 -> improve_flag then strike_flag (equal counts as a strike), with best_cost=50.
REQ-033 In RUN, strike_count is driven to 8 -> done=1 from the next cycle, cost_ready=0, and cost_valid=1 is ignored with cand_count frozen.
REQ-034 start and cost_valid are high together in RUN -> cost_ready=0 that cycle, no flag next cycle, best_valid=0 and cand_count=0.
REQ-035 300 candidates of decreasing cost -> cand_count saturates at 255 and improve_flag pulses 300 times.
REQ-036 rst is asserted with cost_valid=1 mid-RUN -> the next cycle shows IDLE with every output 0, including best_cost, and no flag.

Source files
------------

// File: rtl/strike_detector.sv
// ---------------------------------------------------------------------------
// strike_detector
//
// Tracks the lowest-cost candidate seen during a search. Each accepted
// candidate either improves the best cost (improve_flag pulse) or counts as
// a strike (strike_flag pulse). An equal cost is a strike. The strike flags
// feed an external counter whose value comes back on strike_count. Once that
// count reaches STRIKE_LIMIT the search terminates and done is raised. A new
// start clears the search record and begins again from any state.
//
// Ports
//   clk           in   clock, rising edge
//   rst           in   synchronous reset, active high
//   start         in   one-cycle request to begin or restart a search
//   cost_in       in   candidate cost, unsigned, COST_W bits
//   cost_valid    in   cost_in is valid this cycle
//   cost_ready    out  candidate is accepted this cycle (combinational)
//   strike_count  in   strike total fed back from the downstream counter
//   strike_flag   out  registered pulse: accepted candidate did not improve
//   improve_flag  out  registered pulse: accepted candidate is the new best
//   best_cost     out  lowest cost accepted since the last start
//   best_valid    out  best_cost holds at least one accepted candidate
//   cand_count    out  candidates accepted since the last start, sat. at 255
//   done          out  search terminated on the strike limit
// ---------------------------------------------------------------------------
module strike_detector #(
    parameter int          COST_W       = 16,
    parameter logic [3:0]  STRIKE_LIMIT = 4'd8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [COST_W-1:0] cost_in,
    input  logic              cost_valid,
    output logic              cost_ready,
    input  logic [3:0]        strike_count,
    output logic              strike_flag,
    output logic              improve_flag,
    output logic [COST_W-1:0] best_cost,
    output logic              best_valid,
    output logic [7:0]        cand_count,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } stateT;

    stateT             state_q, state_d;
    logic [COST_W-1:0] bestCost_q, bestCost_d;
    logic              bestValid_q, bestValid_d;
    logic [7:0]        candCount_q, candCount_d;
    logic              strikeFlag_q, strikeFlag_d;
    logic              improveFlag_q, improveFlag_d;
    logic              done_q, done_d;
    logic              accept;
    logic              improves;

    // A start in the same cycle always wins over a candidate, so the source
    // sees ready low and must hold its data for a later cycle.
    assign cost_ready = (state_q == RUN) & ~start;
    assign accept     = cost_valid & cost_ready;

    // The very first candidate of a search is always the best so far.
    assign improves   = ~bestValid_q | (cost_in < bestCost_q);

    // Next-state and next-output computation. Flags default low so they can
    // only pulse in the cycle right after an acceptance.
    always_comb begin
        state_d       = state_q;
        bestCost_d    = bestCost_q;
        bestValid_d   = bestValid_q;
        candCount_d   = candCount_q;
        strikeFlag_d  = 1'b0;
        improveFlag_d = 1'b0;
        done_d        = done_q;

        if (start) begin
            bestCost_d  = '0;
            bestValid_d = 1'b0;
            candCount_d = 8'd0;
            done_d      = 1'b0;
            case (state_q)
                IDLE, RUN, DONE: state_d = RUN;
                default:         state_d = IDLE;
            endcase
        end else begin
            case (state_q)
                IDLE: state_d = IDLE;
                RUN: begin
                    // A candidate arriving in the same cycle as the limit is
                    // still evaluated and still pulses its flag.
                    if (accept) begin
                        if (candCount_q != 8'hFF) begin
                            candCount_d = candCount_q + 8'd1;
                        end
                        if (improves) begin
                            bestCost_d    = cost_in;
                            bestValid_d   = 1'b1;
                            improveFlag_d = 1'b1;
                        end else begin
                            strikeFlag_d  = 1'b1;
                        end
                    end
                    if (strike_count >= STRIKE_LIMIT) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    // State register. Reset clears everything and overrides start and any
    // candidate presented in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            bestCost_q    <= '0;
            bestValid_q   <= 1'b0;
            candCount_q   <= 8'd0;
            strikeFlag_q  <= 1'b0;
            improveFlag_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            bestCost_q    <= bestCost_d;
            bestValid_q   <= bestValid_d;
            candCount_q   <= candCount_d;
            strikeFlag_q  <= strikeFlag_d;
            improveFlag_q <= improveFlag_d;
            done_q        <= done_d;
        end
    end

    assign strike_flag  = strikeFlag_q;
    assign improve_flag = improveFlag_q;
    assign best_cost    = bestCost_q;
    assign best_valid   = bestValid_q;
    assign cand_count   = candCount_q;
    assign done         = done_q;

endmodule

// File: tb/tb_strike_detector.sv
// ---------------------------------------------------------------------------
// tb_strike_detector
//
// Directed bench for strike_detector. Inputs change 1 ns after each rising
// edge; registered outputs are checked there, combinational cost_ready is
// checked 1 ns after the inputs settle.
// ---------------------------------------------------------------------------
module tb_strike_detector;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] cost_in;
    logic        cost_valid;
    logic        cost_ready;
    logic [3:0]  strike_count;
    logic        strike_flag;
    logic        improve_flag;
    logic [15:0] best_cost;
    logic        best_valid;
    logic [7:0]  cand_count;
    logic        done;

    int assertCount;
    int failCount;
    int improveSeen;

    strike_detector #(
        .COST_W       (16),
        .STRIKE_LIMIT (4'd8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .cost_in      (cost_in),
        .cost_valid   (cost_valid),
        .cost_ready   (cost_ready),
        .strike_count (strike_count),
        .strike_flag  (strike_flag),
        .improve_flag (improve_flag),
        .best_cost    (best_cost),
        .best_valid   (best_valid),
        .cand_count   (cand_count),
        .done         (done)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counted, asserted, and reported on mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
            $error("[TB] assertion %s did not hold", tag);
        end
    endtask

    // Drive a set of inputs, then advance one clock to just after the edge.
    task automatic applyStimulus(input logic st, input logic vld,
                                 input logic [15:0] cost, input logic [3:0] sc);
        start        = st;
        cost_valid   = vld;
        cost_in      = cost;
        strike_count = sc;
        @(posedge clk);
        #1;
    endtask

    // Check every registered output at once.
    task automatic checkAll(input string tag, input logic sf, input logic imf,
                            input logic [15:0] bc, input logic bv,
                            input logic [7:0] cc, input logic dn);
        checkOutput({tag, ".strike"},  {31'd0, strike_flag},  {31'd0, sf});
        checkOutput({tag, ".improve"}, {31'd0, improve_flag}, {31'd0, imf});
        checkOutput({tag, ".best"},    {16'd0, best_cost},    {16'd0, bc});
        checkOutput({tag, ".bvalid"},  {31'd0, best_valid},   {31'd0, bv});
        checkOutput({tag, ".count"},   {24'd0, cand_count},   {24'd0, cc});
        checkOutput({tag, ".done"},    {31'd0, done},         {31'd0, dn});
    endtask

    initial begin
        assertCount  = 0;
        failCount    = 0;
        improveSeen  = 0;
        rst          = 1'b1;
        start        = 1'b0;
        cost_in      = '0;
        cost_valid   = 1'b0;
        strike_count = 4'd0;

        // Reset state
        applyStimulus(1'b0, 1'b0, 16'd0, 4'd0);
        applyStimulus(1'b0, 1'b0, 16'd0, 4'd0);
        rst = 1'b0;
        #1;
        checkAll("reset", 1'b0, 1'b0, 16'd0, 1'b0, 8'd0, 1'b0);
        checkOutput("reset.ready", {31'd0, cost_ready}, 32'd0);

        // IDLE ignores candidates
        applyStimulus(1'b0, 1'b1, 16'd5, 4'd0);
        checkAll("idle", 1'b0, 1'b0, 16'd0, 1'b0, 8'd0, 1'b0);

        // 100, 80, 90 after start
        applyStimulus(1'b1, 1'b0, 16'd0, 4'd0);
        start = 1'b0;
        #1;
        checkOutput("run.ready", {31'd0, cost_ready}, 32'd1);
        applyStimulus(1'b0, 1'b1, 16'd100, 4'd0);
        checkAll("c100", 1'b0, 1'b1, 16'd100, 1'b1, 8'd1, 1'b0);
        applyStimulus(1'b0, 1'b1, 16'd80, 4'd0);
        checkAll("c80", 1'b0, 1'b1, 16'd80, 1'b1, 8'd2, 1'b0);
        applyStimulus(1'b0, 1'b1, 16'd90, 4'd0);
        checkAll("c90", 1'b1, 1'b0, 16'd80, 1'b1, 8'd3, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'd0, 4'd0);
        checkAll("quiet", 1'b0, 1'b0, 16'd80, 1'b1, 8'd3, 1'b0);

        // Restart, then 50 twice: equal cost is a strike
        applyStimulus(1'b1, 1'b0, 16'd0, 4'd0);
        checkAll("restart", 1'b0, 1'b0, 16'd0, 1'b0, 8'd0, 1'b0);
        applyStimulus(1'b0, 1'b1, 16'd50, 4'd0);
        checkAll("c50a", 1'b0, 1'b1, 16'd50, 1'b1, 8'd1, 1'b0);
        applyStimulus(1'b0, 1'b1, 16'd50, 4'd0);
        checkAll("c50b", 1'b1, 1'b0, 16'd50, 1'b1, 8'd2, 1'b0);

        // start and cost_valid together: start wins
        start      = 1'b1;
        cost_valid = 1'b1;
        cost_in    = 16'd7;
        #1;
        checkOutput("startwin.ready", {31'd0, cost_ready}, 32'd0);
        applyStimulus(1'b1, 1'b1, 16'd7, 4'd0);
        checkAll("startwin", 1'b0, 1'b0, 16'd0, 1'b0, 8'd0, 1'b0);

        // Strike limit reached with a candidate in the same cycle
        applyStimulus(1'b0, 1'b1, 16'd40, 4'd8);
        checkAll("limit", 1'b0, 1'b1, 16'd40, 1'b1, 8'd1, 1'b1);
        cost_valid = 1'b1;
        start      = 1'b0;
        #1;
        checkOutput("done.ready", {31'd0, cost_ready}, 32'd0);
        applyStimulus(1'b0, 1'b1, 16'd10, 4'd8);
        checkAll("donehold", 1'b0, 1'b0, 16'd40, 1'b1, 8'd1, 1'b1);
        applyStimulus(1'b0, 1'b0, 16'd0, 4'd0);
        checkAll("donestay", 1'b0, 1'b0, 16'd40, 1'b1, 8'd1, 1'b1);

        // Start from DONE, then 300 decreasing costs
        applyStimulus(1'b1, 1'b0, 16'd0, 4'd0);
        checkAll("fromdone", 1'b0, 1'b0, 16'd0, 1'b0, 8'd0, 1'b0);
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b0, 1'b1, 16'(1000 - i), 4'd0);
            if (improve_flag === 1'b1) improveSeen++;
            if (i == 254) checkOutput("sat.255", {24'd0, cand_count}, 32'd255);
        end
        checkOutput("sat.improves", improveSeen, 32'd300);
        checkAll("sat", 1'b0, 1'b1, 16'd701, 1'b1, 8'd255, 1'b0);

        // Reset mid-RUN with a candidate present
        rst = 1'b1;
        applyStimulus(1'b0, 1'b1, 16'd3, 4'd0);
        rst        = 1'b0;
        cost_valid = 1'b0;
        #1;
        checkAll("midrst", 1'b0, 1'b0, 16'd0, 1'b0, 8'd0, 1'b0);
        checkOutput("midrst.ready", {31'd0, cost_ready}, 32'd0);
        applyStimulus(1'b0, 1'b1, 16'd3, 4'd0);
        checkAll("postrst", 1'b0, 1'b0, 16'd0, 1'b0, 8'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
